// File: rtl/calc1_pkg.sv
// calc1_pkg: shared calc1 command/response encodings and driver FSM states
package calc1_pkg;
  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_SUCC = 2'd1,
    RESP_INOF = 2'd2,
    RESP_IERR = 2'd3
  } resp_e;
  typedef enum logic [2:0] {
    IDLE,
    SEND1,
    SEND2,
    WAIT,
    REPORT
  } state_e;
endpackage

// File: rtl/calc1_port_driver_if.sv
// calc1_port_driver_if: transaction, calc1 port and result signals of the port driver
interface calc1_port_driver_if;
  logic        txn_valid;
  logic        txn_ready;
  logic [3:0]  txn_cmd;
  logic [31:0] txn_op1;
  logic [31:0] txn_op2;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  duv_resp;
  logic [31:0] duv_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        stray_resp;
  modport master (
    input  txn_valid, txn_cmd, txn_op1, txn_op2, duv_resp, duv_data, rsp_ready,
    output txn_ready, req_cmd_out, req_data_out, rsp_valid, rsp_resp, rsp_data,
           rsp_timeout, stray_resp
  );
  modport slave (
    output txn_valid, txn_cmd, txn_op1, txn_op2, duv_resp, duv_data, rsp_ready,
    input  txn_ready, req_cmd_out, req_data_out, rsp_valid, rsp_resp, rsp_data,
           rsp_timeout, stray_resp
  );
endinterface

// File: rtl/calc1_drv_timer.sv
// calc1_drv_timer: 8-bit wait counter; expired fires on the cycle the count would reach TIMEOUT
module calc1_drv_timer #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 8'd1 : cnt;
  assign expired = en && (cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/calc1_port_driver.sv
// calc1_port_driver: drives one calc1 transaction (cmd+op1, op2), waits for a response or timeout, reports it
module calc1_port_driver
  import calc1_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32
) (
  input logic c_clk,
  input logic reset,
  calc1_port_driver_if.master bus
);
  state_e      st, nxt;
  logic [31:0] op2_q, d_op2;
  logic [3:0]  d_req_cmd;
  logic [31:0] d_req_data;
  logic [1:0]  d_resp;
  logic [31:0] d_data;
  logic        d_to;
  logic        expired;
  logic        got_resp;
  assign got_resp = bus.duv_resp != RESP_NONE;
  calc1_drv_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (c_clk),
    .rst     (reset),
    .clr     (st != WAIT),
    .en      (st == WAIT && !got_resp),
    .expired (expired)
  );
  always_comb begin
    nxt        = st;
    d_op2      = op2_q;
    d_req_cmd  = '0;
    d_req_data = '0;
    d_resp     = bus.rsp_resp;
    d_data     = bus.rsp_data;
    d_to       = bus.rsp_timeout;
    case (st)
      IDLE: if (bus.txn_valid && bus.txn_ready) begin
        d_op2 = bus.txn_op2;
        if (bus.txn_cmd == CMD_NOP) begin
          nxt    = REPORT;
          d_resp = RESP_NONE;
          d_data = '0;
          d_to   = 1'b0;
        end else begin
          nxt        = SEND1;
          d_req_cmd  = bus.txn_cmd;
          d_req_data = bus.txn_op1;
        end
      end
      SEND1: begin
        nxt        = SEND2;
        d_req_data = op2_q;
      end
      SEND2, WAIT: if (got_resp) begin
        nxt    = REPORT;
        d_resp = bus.duv_resp;
        d_data = bus.duv_data;
        d_to   = 1'b0;
      end else if (st == SEND2) nxt = WAIT;
      else if (expired) begin
        nxt    = REPORT;
        d_resp = RESP_NONE;
        d_data = '0;
        d_to   = 1'b1;
      end
      REPORT: if (bus.rsp_ready) begin
        nxt    = IDLE;
        d_resp = RESP_NONE;
        d_data = '0;
        d_to   = 1'b0;
      end
      default: nxt = IDLE;
    endcase
  end
  // txn_ready is registered so it stays low through reset and rises on the first edge after release
  always_ff @(posedge c_clk or posedge reset)
    if (reset) begin
      st               <= IDLE;
      op2_q            <= '0;
      bus.txn_ready    <= 1'b0;
      bus.req_cmd_out  <= '0;
      bus.req_data_out <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_resp     <= '0;
      bus.rsp_data     <= '0;
      bus.rsp_timeout  <= 1'b0;
      bus.stray_resp   <= 1'b0;
    end else begin
      st               <= nxt;
      op2_q            <= d_op2;
      bus.txn_ready    <= nxt == IDLE;
      bus.req_cmd_out  <= d_req_cmd;
      bus.req_data_out <= d_req_data;
      bus.rsp_valid    <= nxt == REPORT;
      bus.rsp_resp     <= d_resp;
      bus.rsp_data     <= d_data;
      bus.rsp_timeout  <= d_to;
      bus.stray_resp   <= bus.stray_resp || (got_resp && st inside {IDLE, SEND1, REPORT});
    end
endmodule

// File: doc/calc1_port_driver.md
CALC1_PORT_DRIVER -- requirements
Module: calc1_port_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32, meaning the maximum number of WAIT cycles before a transaction is abandoned (legal range 1..255).
REQ-002 SHALL have port c_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port txn_valid  input  1  a transaction is offered.
REQ-005 SHALL have port txn_ready  output  1  the driver can accept a transaction.
REQ-006 SHALL have port txn_cmd  input  4  calc1 command (0 nop, 1 add, 2 sub, 5 shl, 6 shr).
REQ-007 SHALL have ports txn_op1 and txn_op2  input  32 each  first and second operands.
REQ-008 SHALL have ports req_cmd_out (output, 4) and req_data_out (output, 32)  command and data driven to the calc1 port.
REQ-009 SHALL have ports duv_resp (input, 2) and duv_data (input, 32)  the response and result from the calc1 port.
REQ-010 SHALL have port rsp_valid  output  1  a completed result is available.
REQ-011 SHALL have port rsp_ready  input  1  the consumer accepts the result.
REQ-012 SHALL have ports rsp_resp (output, 2), rsp_data (output, 32) and rsp_timeout (output, 1)  captured response, captured data, and timeout flag.
REQ-013 SHALL have port stray_resp  output  1  sticky flag for a non-zero duv_resp outside a response window.

Function
REQ-014 SHALL implement the FSM states IDLE, SEND1, SEND2, WAIT and REPORT, with IDLE as the reset state.
REQ-015 SHALL assert txn_ready only in IDLE; txn_valid&&txn_ready at edge N captures cmd, op1 and op2.
REQ-016 SHALL, for a non-zero cmd, go IDLE->SEND1; req_cmd_out=cmd and req_data_out=op1 during cycle N+1 (registered outputs).
REQ-017 SHALL go SEND1->SEND2 unconditionally; req_cmd_out=0 and req_data_out=op2 during cycle N+2.
REQ-018 SHALL go SEND2->WAIT unconditionally; req_cmd_out=0 and req_data_out=0 in WAIT, REPORT and IDLE.
REQ-019 SHALL, for cmd=0, go IDLE->REPORT directly, drive nothing, and report rsp_resp=0, rsp_data=0, rsp_timeout=0.
REQ-020 SHALL sample duv_resp in SEND2 and WAIT; the first non-zero value captures duv_resp/duv_data into rsp_resp/rsp_data and the FSM goes to REPORT.
REQ-021 SHALL clear an 8-bit wait counter on entry to WAIT and increment it each WAIT cycle without a response.
REQ-022 SHALL, when the counter reaches TIMEOUT with no response, go to REPORT with rsp_timeout=1, rsp_resp=0 and rsp_data=0.
REQ-023 SHALL give a response priority over a timeout occurring in the same cycle (rsp_timeout=0).
REQ-024 SHALL assert rsp_valid only in REPORT and hold rsp_resp/rsp_data/rsp_timeout stable until rsp_valid&&rsp_ready, then return to IDLE (txn_ready=1 on the next cycle).
REQ-025 SHALL set stray_resp when duv_resp!=0 in IDLE, SEND1 or REPORT; it stays set until reset.
REQ-026 SHALL apply no arithmetic to the operands or results; the data path is pass-through and capture only.

Reset
REQ-027 SHALL, while reset is high, immediately force state=IDLE, all outputs=0 and the counter=0, independent of c_clk.
REQ-028 SHALL abandon any in-flight transaction on reset mid-operation, with no rsp_valid for it; txn_ready=1 on the first edge after reset is released.

Structure
REQ-029 SHALL take the command encodings, the response encodings (NONE 0, SUCC 1, INOF 2, IERR 3) and the FSM state type from the shared package calc1_pkg.
REQ-030 SHALL contain exactly one sub-module, calc1_drv_timer (wait counter with clear, enable and expired outputs); the FSM and data capture stay in the top.

Verification
REQ-031 SHALL verify add: cmd=1, op1=5, op2=3; DUV returns resp=1, data=8 on the 3rd WAIT cycle -> rsp_valid=1, rsp_resp=1, rsp_data=8, rsp_timeout=0.
REQ-032 SHALL verify timeout: TIMEOUT=4, cmd=2, no response -> rsp_valid after 4 WAIT cycles with rsp_timeout=1, rsp_resp=0, rsp_data=0.
REQ-033 SHALL verify backpressure: rsp_ready held low for 5 cycles in REPORT -> outputs stable and txn_ready=0; rsp_ready=1 -> IDLE, txn_ready=1 on the next cycle.
REQ-034 SHALL verify stray response: duv_resp=2 while in IDLE -> stray_resp=1, FSM state unchanged, flag persists until reset.
REQ-035 SHALL verify reset in WAIT: reset pulsed high on cycle 2 of WAIT -> all outputs 0 immediately, no rsp_valid, txn_ready=1 after release.
REQ-036 SHALL verify nop: cmd=0, op1=0xFFFFFFFF -> req_cmd_out stays 0, rsp_valid=1 on cycle N+1 with rsp_resp=0.
